// File: rtl/vtx_retire_buffer.sv
// ---------------------------------------------------------------------------
// vtx_retire_buffer
//
// Captures one transaction per retired instruction and queues it for
// downstream checkers. Each transaction holds the instruction fields plus the
// pre- and post-retire values of the destination CPR, which is selected from
// flattened register-file snapshots. Entries leave through a valid/ready
// handshake in strict FIFO order. Every retire gets a sequence number, so a
// consumer can see exactly where transactions were dropped.
//
// Ports
//   vtx_clk, vtx_reset     clock (posedge) and synchronous active-high reset
//   vtx_valid              retire strobe, at most one instruction per cycle
//   vtx_instr_*            instruction encoding, rs1, result code, GPR write
//   vtx_crd_idx            destination CPR index
//   vtx_cprs_pre/post      NREG x XLEN snapshots, reg i at [i*XLEN +: XLEN]
//   out_valid/out_ready    head handshake toward the consumer
//   out_*                  head entry fields; all zero while out_valid is low
//   out_crd_pre/post       head pre/post value of CPR[out_crd_idx]
//   out_seq                head sequence number (retire_count at capture)
//   count                  current occupancy, 0..DEPTH
//   overflow               sticky, set by the first dropped transaction
//   drop_count             dropped transactions, saturating
//   retire_count           every vtx_valid pulse seen, wrapping
// ---------------------------------------------------------------------------
module vtx_retire_buffer #(
    parameter int XLEN             = 32,
    parameter int NREG             = 16,
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 32,
    parameter bit STOP_ON_OVERFLOW = 1'b0
) (
    input  logic                       vtx_clk,
    input  logic                       vtx_reset,

    input  logic                       vtx_valid,
    input  logic [31:0]                vtx_instr_enc,
    input  logic [XLEN-1:0]            vtx_instr_rs1,
    input  logic [2:0]                 vtx_instr_result,
    input  logic [XLEN-1:0]            vtx_instr_wdata,
    input  logic [4:0]                 vtx_instr_waddr,
    input  logic                       vtx_instr_wen,
    input  logic [$clog2(NREG)-1:0]    vtx_crd_idx,
    input  logic [NREG*XLEN-1:0]       vtx_cprs_pre,
    input  logic [NREG*XLEN-1:0]       vtx_cprs_post,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr_enc,
    output logic [XLEN-1:0]            out_instr_rs1,
    output logic [2:0]                 out_instr_result,
    output logic [XLEN-1:0]            out_instr_wdata,
    output logic [4:0]                 out_instr_waddr,
    output logic                       out_instr_wen,
    output logic [$clog2(NREG)-1:0]    out_crd_idx,
    output logic [XLEN-1:0]            out_crd_pre,
    output logic [XLEN-1:0]            out_crd_post,
    output logic [CNT_W-1:0]           out_seq,

    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           retire_count
);

    localparam int IDX_W = $clog2(NREG);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_CNT = OCC_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      enc;
        logic [XLEN-1:0]  rs1;
        logic [2:0]       result;
        logic [XLEN-1:0]  wdata;
        logic [4:0]       waddr;
        logic             wen;
        logic [IDX_W-1:0] crd_idx;
        logic [XLEN-1:0]  crd_pre;
        logic [XLEN-1:0]  crd_post;
        logic [CNT_W-1:0] seq;
    } entry_t;

    // -----------------------------------------------------------------------
    // Destination CPR selection: view each flat snapshot as an array of
    // registers so the selection is a plain indexed read.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] pre_regs  [NREG];
    logic [XLEN-1:0] post_regs [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_slice
        assign pre_regs[i]  = vtx_cprs_pre[i*XLEN +: XLEN];
        assign post_regs[i] = vtx_cprs_post[i*XLEN +: XLEN];
    end

    entry_t in_entry;

    always_comb begin
        in_entry          = '0;
        in_entry.enc      = vtx_instr_enc;
        in_entry.rs1      = vtx_instr_rs1;
        in_entry.result   = vtx_instr_result;
        in_entry.wdata    = vtx_instr_wdata;
        in_entry.waddr    = vtx_instr_waddr;
        in_entry.wen      = vtx_instr_wen;
        in_entry.crd_idx  = vtx_crd_idx;
        in_entry.crd_pre  = pre_regs[vtx_crd_idx];
        in_entry.crd_post = post_regs[vtx_crd_idx];
        // The sequence number is the retire count before this retire bumps it.
        in_entry.seq      = retire_count;
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             full;
    logic             blocked;
    logic             push;
    logic             drop;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == DEPTH_CNT);
    assign blocked   = STOP_ON_OVERFLOW & overflow;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = vtx_valid & ~blocked & (~full | pop);
    assign drop      = vtx_valid & ~push;

    always_ff @(posedge vtx_clk) begin
        if (vtx_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            drop_count   <= '0;
            retire_count <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop) begin
                count <= count + OCC_W'(1);
            end else if (pop && !push) begin
                count <= count - OCC_W'(1);
            end

            if (vtx_valid) retire_count <= retire_count + CNT_W'(1);

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Storage is not reset: occupancy alone decides what is live, and a write
    // during reset lands in a slot that the reset pointers treat as empty.
    always_ff @(posedge vtx_clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    // -----------------------------------------------------------------------
    // Head presentation: no bypass, so a freshly pushed entry appears the
    // cycle after its push. Fields are zeroed while nothing is valid.
    // -----------------------------------------------------------------------
    entry_t head;

    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign out_instr_enc    = head.enc;
    assign out_instr_rs1    = head.rs1;
    assign out_instr_result = head.result;
    assign out_instr_wdata  = head.wdata;
    assign out_instr_waddr  = head.waddr;
    assign out_instr_wen    = head.wen;
    assign out_crd_idx      = head.crd_idx;
    assign out_crd_pre      = head.crd_pre;
    assign out_crd_post     = head.crd_post;
    assign out_seq          = head.seq;

endmodule

// File: tb/tb_vtx_retire_buffer.sv
// ---------------------------------------------------------------------------
// tb_vtx_retire_buffer
//
// Drives two buffer instances: u_dut uses the default parameters and is
// checked by a scoreboard, and u_stop has STOP_ON_OVERFLOW=1 and is checked
// by direct comparisons. Stimulus changes 1 time unit after each posedge.
// The monitor samples on the negedge, where it compares popped heads, checks
// that the head holds under backpressure, and checks that empty outputs are
// zero.
// ---------------------------------------------------------------------------
module tb_vtx_retire_buffer;

    localparam int XLEN  = 32;
    localparam int NREG  = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int HW    = 32 + XLEN + 3 + XLEN + 5 + 1 + 4 + XLEN + XLEN + CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared instruction/data inputs
    logic [31:0]          instr_enc    = '0;
    logic [XLEN-1:0]      instr_rs1    = '0;
    logic [2:0]           instr_result = '0;
    logic [XLEN-1:0]      instr_wdata  = '0;
    logic [4:0]           instr_waddr  = '0;
    logic                 instr_wen    = 1'b0;
    logic [3:0]           crd_idx      = '0;
    logic [NREG*XLEN-1:0] cprs_pre     = '0;
    logic [NREG*XLEN-1:0] cprs_post    = '0;

    // main instance
    logic                 vtx_reset = 1'b1;
    logic                 vtx_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [31:0]          out_instr_enc;
    logic [XLEN-1:0]      out_instr_rs1;
    logic [2:0]           out_instr_result;
    logic [XLEN-1:0]      out_instr_wdata;
    logic [4:0]           out_instr_waddr;
    logic                 out_instr_wen;
    logic [3:0]           out_crd_idx;
    logic [XLEN-1:0]      out_crd_pre;
    logic [XLEN-1:0]      out_crd_post;
    logic [CNT_W-1:0]     out_seq;
    logic [2:0]           count;
    logic                 overflow;
    logic [CNT_W-1:0]     drop_count;
    logic [CNT_W-1:0]     retire_count;

    // stop-on-overflow instance
    logic                 s_reset = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready = 1'b0;
    logic                 s_out_valid;
    logic [31:0]          s_enc;
    logic [XLEN-1:0]      s_rs1;
    logic [2:0]           s_result;
    logic [XLEN-1:0]      s_wdata;
    logic [4:0]           s_waddr;
    logic                 s_wen;
    logic [3:0]           s_idx;
    logic [XLEN-1:0]      s_pre;
    logic [XLEN-1:0]      s_post;
    logic [CNT_W-1:0]     s_seq;
    logic [2:0]           s_count;
    logic                 s_overflow;
    logic [CNT_W-1:0]     s_drop;
    logic [CNT_W-1:0]     s_retire;

    vtx_retire_buffer #(
        .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_OVERFLOW(1'b0)
    ) u_dut (
        .vtx_clk(clk), .vtx_reset(vtx_reset), .vtx_valid(vtx_valid),
        .vtx_instr_enc(instr_enc), .vtx_instr_rs1(instr_rs1),
        .vtx_instr_result(instr_result), .vtx_instr_wdata(instr_wdata),
        .vtx_instr_waddr(instr_waddr), .vtx_instr_wen(instr_wen),
        .vtx_crd_idx(crd_idx), .vtx_cprs_pre(cprs_pre), .vtx_cprs_post(cprs_post),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr_enc(out_instr_enc), .out_instr_rs1(out_instr_rs1),
        .out_instr_result(out_instr_result), .out_instr_wdata(out_instr_wdata),
        .out_instr_waddr(out_instr_waddr), .out_instr_wen(out_instr_wen),
        .out_crd_idx(out_crd_idx), .out_crd_pre(out_crd_pre), .out_crd_post(out_crd_post),
        .out_seq(out_seq), .count(count), .overflow(overflow),
        .drop_count(drop_count), .retire_count(retire_count)
    );

    vtx_retire_buffer #(
        .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_OVERFLOW(1'b1)
    ) u_stop (
        .vtx_clk(clk), .vtx_reset(s_reset), .vtx_valid(s_valid),
        .vtx_instr_enc(instr_enc), .vtx_instr_rs1(instr_rs1),
        .vtx_instr_result(instr_result), .vtx_instr_wdata(instr_wdata),
        .vtx_instr_waddr(instr_waddr), .vtx_instr_wen(instr_wen),
        .vtx_crd_idx(crd_idx), .vtx_cprs_pre(cprs_pre), .vtx_cprs_post(cprs_post),
        .out_valid(s_out_valid), .out_ready(s_ready),
        .out_instr_enc(s_enc), .out_instr_rs1(s_rs1),
        .out_instr_result(s_result), .out_instr_wdata(s_wdata),
        .out_instr_waddr(s_waddr), .out_instr_wen(s_wen),
        .out_crd_idx(s_idx), .out_crd_pre(s_pre), .out_crd_post(s_post),
        .out_seq(s_seq), .count(s_count), .overflow(s_overflow),
        .drop_count(s_drop), .retire_count(s_retire)
    );

    int checks = 0;
    int errors = 0;

    logic [HW-1:0] sb[$];
    logic [CNT_W-1:0] exp_seq = '0;

    logic [HW-1:0] head;
    assign head = {out_instr_enc, out_instr_rs1, out_instr_result, out_instr_wdata,
                   out_instr_waddr, out_instr_wen, out_crd_idx, out_crd_pre,
                   out_crd_post, out_seq};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction. Every register except the destination carries
    // filler, so a wrong slice shows up as a wrong pre/post value.
    task automatic set_data(input logic [31:0] enc, input logic [3:0] idx,
                            input logic [31:0] pre_v, input logic [31:0] post_v);
        for (int i = 0; i < NREG; i++) begin
            cprs_pre[i*XLEN +: XLEN]  = 32'h5A00_0000 + i;
            cprs_post[i*XLEN +: XLEN] = 32'hA500_0000 + i;
        end
        cprs_pre[int'(idx)*XLEN +: XLEN]  = pre_v;
        cprs_post[int'(idx)*XLEN +: XLEN] = post_v;
        instr_enc    = enc;
        instr_rs1    = ~enc;
        instr_result = enc[2:0];
        instr_wdata  = enc + 32'h100;
        instr_waddr  = enc[11:7];
        instr_wen    = enc[0];
        crd_idx      = idx;
    endtask

    // sel=0 drives the main instance (scoreboarded), sel=1 the stop instance.
    task automatic issue(input bit sel, input logic [31:0] enc, input logic [3:0] idx,
                         input logic [31:0] pre_v, input logic [31:0] post_v,
                         input bit will_push);
        set_data(enc, idx, pre_v, post_v);
        if (!sel) begin
            vtx_valid = 1'b1;
            if (will_push)
                sb.push_back({enc, ~enc, enc[2:0], enc + 32'h100, enc[11:7], enc[0],
                              idx, pre_v, post_v, exp_seq});
            exp_seq++;
        end else begin
            s_valid = 1'b1;
        end
        tick();
        vtx_valid = 1'b0;
        s_valid   = 1'b0;
    endtask

    task automatic reset_main();
        vtx_reset = 1'b1;
        out_ready = 1'b0;
        vtx_valid = 1'b0;
        sb.delete();
        exp_seq = '0;
        tick();
        vtx_reset = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // monitor
    logic          prev_hold = 1'b0;
    logic [HW-1:0] prev_head = '0;

    always @(negedge clk) begin
        if (prev_hold) begin
            chk("hold_stable", head, prev_head);
            chk("hold_valid", out_valid, 1'b1);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got seq %0d expected no entry", out_seq);
            end else begin
                chk("pop_head", head, sb.pop_front());
            end
        end
        if (!out_valid && !vtx_reset) chk("empty_zero", head, '0);
        prev_hold = out_valid && !out_ready && !vtx_reset;
        prev_head = head;
    end

    initial begin
        // 1: reset with vtx_valid high, then idle
        set_data(32'h0000_0013, 4'd3, 32'h1, 32'h2);
        vtx_valid = 1'b1;
        s_valid   = 1'b1;
        tick();
        tick();
        vtx_reset = 1'b0;
        s_reset   = 1'b0;
        vtx_valid = 1'b0;
        s_valid   = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_head", head, '0);
        tick();

        // 2: single push then pop
        issue(0, 32'h0000_702B, 4'd5, 32'hDEADBEEF, 32'h12345678, 1);
        chk("t2_valid", out_valid, 1);
        chk("t2_pre", out_crd_pre, 32'hDEADBEEF);
        chk("t2_post", out_crd_post, 32'h12345678);
        chk("t2_seq", out_seq, 0);
        chk("t2_enc", out_instr_enc, 32'h0000_702B);
        drain(1);
        chk("t2_count", count, 0);
        chk("t2_retire", retire_count, 1);

        // 3: fill and overflow
        reset_main();
        for (int k = 0; k < 6; k++)
            issue(0, 32'h0000_1000 + k, 4'(k), 32'hC000_0000 + k, 32'hD000_0000 + k, k < 4);
        chk("t3_count", count, 4);
        chk("t3_drop", drop_count, 2);
        chk("t3_overflow", overflow, 1);
        chk("t3_retire", retire_count, 6);
        drain(4);
        chk("t3_empty", count, 0);
        chk("t3_sb", sb.size(), 0);

        // 4: full with simultaneous push and pop
        reset_main();
        for (int k = 0; k < 4; k++)
            issue(0, 32'h0000_2080 + k, 4'(15 - k), 32'hE000_0000 + k, 32'hF000_0000 + k, 1);
        chk("t4_full", count, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            issue(0, 32'h0000_3101 + k, 4'(k + 8), 32'h7000_0000 + k, 32'h8000_0000 + k, 1);
        chk("t4_count", count, 4);
        chk("t4_drop", drop_count, 0);
        chk("t4_overflow", overflow, 0);
        drain(4);
        chk("t4_empty", count, 0);
        chk("t4_sb", sb.size(), 0);

        // 5: stop-on-overflow instance
        s_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            issue(1, 32'h0000_4000 + k, 4'(k), 32'h3000_0000 + k, 32'h4000_0000 + k, 0);
        chk("t5_count", s_count, 4);
        chk("t5_overflow", s_overflow, 1);
        chk("t5_drop", s_drop, 1);
        s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t5_drain_seq", s_seq, k);
            chk("t5_drain_pre", s_pre, 32'h3000_0000 + k);
            tick();
        end
        s_ready = 1'b0;
        chk("t5_drained", s_count, 0);
        issue(1, 32'h0000_4100, 4'd1, 32'h1, 32'h2, 0);
        issue(1, 32'h0000_4101, 4'd2, 32'h3, 32'h4, 0);
        chk("t5_blocked_count", s_count, 0);
        chk("t5_blocked_drop", s_drop, 3);
        chk("t5_blocked_retire", s_retire, 7);
        chk("t5_blocked_valid", s_out_valid, 0);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        chk("t5_rst_overflow", s_overflow, 0);
        issue(1, 32'h0000_4200, 4'd9, 32'h0BAD_CAFE, 32'h0000_0009, 0);
        chk("t5_resume_count", s_count, 1);
        chk("t5_resume_seq", s_seq, 0);
        chk("t5_resume_pre", s_pre, 32'h0BAD_CAFE);

        // 6: backpressure stability and reset mid-operation
        reset_main();
        for (int k = 0; k < 5; k++)
            issue(0, 32'h0000_5000 + k, 4'(k * 3), 32'h9000_0000 + k, 32'hB000_0000 + k, k < 4);
        chk("t6_overflow", overflow, 1);
        repeat (3) tick();
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b0;
        for (int g = 0; g < 8 && sb.size() > 2; g++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        for (int g = 0; g < 4 && sb.size() < 2; g++)
            issue(0, 32'h0000_6000 + g, 4'(g + 1), 32'h6600_0000 + g, 32'h7700_0000 + g, 1);
        chk("t6_count2", count, 2);
        repeat (2) tick();
        reset_main();
        chk("t6_rst_count", count, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_overflow", overflow, 0);
        chk("t6_rst_drop", drop_count, 0);
        tick();

        chk("end_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vtx_retire_buffer.md
Name: vtx_retire_buffer

Overview:
- Parametrised retire-transaction buffer for the formal/verification environment.
- Captures one transaction per retired instruction (vtx_valid): instruction fields plus pre/post values of the destination CPR, selected from flattened register-file snapshots.
- Queues transactions in a DEPTH-entry FIFO with a valid/ready handshake toward downstream checkers.
- Generalises the fixed 16 x 32-bit register view to NREG x XLEN, adds sequence numbering and overflow accounting.

Parameters:
- XLEN, 32, data width of registers and wdata/rs1.
- NREG, 16, number of CPRs in the snapshot; power of 2, >= 2.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- CNT_W, 32, width of the sequence, retire and drop counters.
- STOP_ON_OVERFLOW, 0, if 1 all pushes are blocked after the first drop until reset.

Ports:
- vtx_clk  in  1  clock; all logic on posedge.
- vtx_reset  in  1  synchronous, active-high reset.
- vtx_valid  in  1  retire strobe; one instruction retires per cycle when high.
- vtx_instr_enc  in  32  instruction encoding.
- vtx_instr_rs1  in  XLEN  rs1 value.
- vtx_instr_result  in  3  result code.
- vtx_instr_wdata  in  XLEN  GPR write data.
- vtx_instr_waddr  in  5  GPR write address.
- vtx_instr_wen  in  1  GPR write enable.
- vtx_crd_idx  in  $clog2(NREG)  destination CPR index.
- vtx_cprs_pre  in  NREG*XLEN  pre-state snapshot; register i at bits [i*XLEN +: XLEN].
- vtx_cprs_post  in  NREG*XLEN  post-state snapshot; same layout.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_instr_enc / out_instr_rs1 / out_instr_result / out_instr_wdata / out_instr_waddr / out_instr_wen / out_crd_idx  out  same widths as inputs  head fields.
- out_crd_pre  out  XLEN  head pre-value of CPR[crd_idx].
- out_crd_post  out  XLEN  head post-value of CPR[crd_idx].
- out_seq  out  CNT_W  head sequence number.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on the first drop.
- drop_count  out  CNT_W  dropped transactions; saturates at all-ones.
- retire_count  out  CNT_W  total vtx_valid pulses seen; wraps.

Behaviour:
- Reset (synchronous, vtx_reset high at posedge):
  - Pointers, count, overflow, drop_count and retire_count go to 0; out_valid goes to 0.
  - Reset has priority over any simultaneous push/pop; an in-flight head entry is discarded.
- Capture:
  - On vtx_valid, CPR[vtx_crd_idx] is sliced combinationally from both snapshots and stored with the instruction fields.
  - seq = retire_count before increment.
- Definitions:
  - pop = out_valid & out_ready.
  - full = (count == DEPTH).
  - blocked = STOP_ON_OVERFLOW & overflow.
- Push condition: push = vtx_valid & !blocked & (!full | pop).
  - Push when full with a simultaneous pop is legal; count stays DEPTH.
- Drop condition: drop = vtx_valid & !push.
  - Sets overflow.
  - Increments drop_count, saturating.
- retire_count increments on every vtx_valid, whether pushed or dropped; it wraps modulo 2^CNT_W.
- count updates: +1 on push only; -1 on pop only; unchanged on both or neither.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no same-cycle bypass when empty.
- out_valid = (count != 0).
- Head stability: while out_valid=1 and out_ready=0, all out_* fields hold stable.
- Empty state: when out_valid=0, all out_* data fields are driven to 0.
- Pop when empty: out_ready=1 with count=0 has no effect.
- Ordering: strict FIFO; out_seq of consecutive pops is strictly increasing (mod 2^CNT_W), with gaps exactly where drops occurred.

Test Plan:
1. Reset then idle: vtx_reset=1 for 2 cycles with vtx_valid=1 -> count=0, out_valid=0, retire_count=0, all out_* data=0.
2. Single push: vtx_valid=1 for one cycle, crd_idx=5, cprs_pre[5]=0xDEADBEEF, cprs_post[5]=0x12345678, enc=0x0000_702B -> the next cycle out_valid=1, out_crd_pre=0xDEADBEEF, out_crd_post=0x12345678, out_seq=0. Then out_ready=1 -> count=0 the following cycle.
3. Fill and overflow (DEPTH=4, out_ready=0): 6 consecutive vtx_valid -> count=4, drop_count=2, overflow=1, retire_count=6. Draining yields out_seq 0,1,2,3.
4. Full with simultaneous push+pop: with count=4, vtx_valid=1 and out_ready=1 for 3 cycles -> count stays 4, drop_count unchanged, popped seq 0,1,2.
5. STOP_ON_OVERFLOW=1: overflow, then drain fully, then 2 more vtx_valid -> no pushes, drop_count increases by 2, count=0. After reset, pushes resume with seq 0.
6. Backpressure stability and reset mid-operation: 2 entries queued, out_ready toggling 0/1 randomly -> out_* stable whenever out_ready=0. Assert vtx_reset with count=2 -> next cycle count=0, out_valid=0, overflow=0.
